// File: rtl/regfile_wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter_if
// Bundles the writeback request bus and the register-file write port that the
// arbiter sits between.
//
// Parameters:
//   NUM_REQ     number of writeback requesters
//
// Signals:
//   ReqValid    [NUM_REQ]     requester i has a write pending
//   ReqReg      [5*NUM_REQ]   destination register, slice [5i+4:5i]
//   ReqData     [32*NUM_REQ]  write data, slice [32i+31:32i]
//   ReqReady    [NUM_REQ]     requester i granted this cycle
//   Hold        1             blocks all grants while high
//   WriteReg1   5             register-file write address
//   WriteData1  32            register-file write data
//   Write1      1             register-file write strobe
//   Pending     1             some valid requester was not granted this cycle
//
// Modports:
//   master  writeback side (drives requests, observes grants and write port)
//   slave   the arbiter
// ---------------------------------------------------------------------------
interface regfile_wb_arbiter_if #(
    parameter int NUM_REQ = 3
);
    logic [NUM_REQ-1:0]    ReqValid;
    logic [5*NUM_REQ-1:0]  ReqReg;
    logic [32*NUM_REQ-1:0] ReqData;
    logic [NUM_REQ-1:0]    ReqReady;
    logic                  Hold;
    logic [4:0]            WriteReg1;
    logic [31:0]           WriteData1;
    logic                  Write1;
    logic                  Pending;

    modport master (
        output ReqValid, ReqReg, ReqData, Hold,
        input  ReqReady, WriteReg1, WriteData1, Write1, Pending
    );

    modport slave (
        input  ReqValid, ReqReg, ReqData, Hold,
        output ReqReady, WriteReg1, WriteData1, Write1, Pending
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
// Shares the single register-file write port among NUM_REQ writeback sources.
// One grant per cycle; the granted write is registered and presented to the
// register file on the following edge. Writes to r0 are accepted but never
// strobed.
//
// Optional feature macro: REGFILE_WB_ARB_RR_EN
//   defined   : round-robin grant, search starts at a pointer that moves to
//               one past the last granted index
//   undefined : fixed priority, lowest index wins, no pointer register
//
// Parameters:
//   NUM_REQ  number of requesters (2..8)
//   PTR_W    round-robin pointer width, 2**PTR_W >= NUM_REQ
//
// Ports:
//   CLK      clock, rising edge
//   RESET    asynchronous active-low reset
//   bus      request bus and register-file write port (slave modport)
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    regfile_wb_arbiter_if.slave   bus
);

    logic [PTR_W-1:0]     basePtr;
    logic [2*NUM_REQ-1:0] validDbl;
    logic [NUM_REQ-1:0]   validRot;
    logic                 eligible;

    logic                 grantAny;
    int                   offset;
    int                   grantPos;
    logic [NUM_REQ-1:0]   grantVec;
    logic [4:0]           selReg;
    logic [31:0]          selData;

    logic [4:0]           writeRegQ;
    logic [31:0]          writeDataQ;
    logic                 writeQ;

`ifdef REGFILE_WB_ARB_RR_EN
    logic [PTR_W-1:0]     ptrQ;
    int                   nextPos;

    // An undecodable pointer behaves as 0.
    assign basePtr = (int'(ptrQ) < NUM_REQ) ? ptrQ : '0;

    always_comb begin
        nextPos = grantPos + 1;
        if (nextPos >= NUM_REQ) begin
            nextPos = 0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ptrQ <= '0;
        end else if (grantAny) begin
            ptrQ <= PTR_W'(nextPos);
        end
    end
`else
    assign basePtr = '0;
`endif

    // Rotating the doubled vector puts the search start at bit 0, so the
    // first set bit is the winner's distance from the pointer.
    assign validDbl = {bus.ReqValid, bus.ReqValid} >> basePtr;
    assign validRot = validDbl[NUM_REQ-1:0];

    // No grants while held or while reset is asserted.
    assign eligible = !bus.Hold && RESET;

    always_comb begin
        grantAny = 1'b0;
        offset   = 0;
        grantPos = 0;
        grantVec = '0;
        selReg   = '0;
        selData  = '0;

        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grantAny && eligible && validRot[k]) begin
                grantAny = 1'b1;
                offset   = k;
            end
        end

        grantPos = int'(basePtr) + offset;
        if (grantPos >= NUM_REQ) begin
            grantPos = grantPos - NUM_REQ;
        end

        for (int i = 0; i < NUM_REQ; i++) begin
            if (grantAny && (grantPos == i)) begin
                grantVec[i] = 1'b1;
                selReg      = bus.ReqReg[5*i +: 5];
                selData     = bus.ReqData[32*i +: 32];
            end
        end
    end

    // Address/data load on every grant (including r0) so the port always shows
    // the last accepted request; only the strobe is suppressed for r0.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            writeRegQ  <= '0;
            writeDataQ <= '0;
            writeQ     <= 1'b0;
        end else begin
            writeQ <= grantAny && (selReg != 5'd0);
            if (grantAny) begin
                writeRegQ  <= selReg;
                writeDataQ <= selData;
            end
        end
    end

    assign bus.ReqReady   = grantVec;
    assign bus.Pending    = |(bus.ReqValid & ~grantVec);
    assign bus.WriteReg1  = writeRegQ;
    assign bus.WriteData1 = writeDataQ;
    assign bus.Write1     = writeQ;

endmodule
